// File: rtl/psram_qspi_responder_if.sv
// QSPI link between a PSRAM controller (master) and the PSRAM responder (slave).
interface psram_qspi_responder_if;
  logic       qspi_sck;
  logic       qspi_ce_n;
  logic [3:0] dio_in;
  logic [3:0] dio_out;
  logic [3:0] dio_oen;
  logic       busy;

  modport master (
    output qspi_sck, qspi_ce_n, dio_in,
    input  dio_out, dio_oen, busy
  );

  modport slave (
    input  qspi_sck, qspi_ce_n, dio_in,
    output dio_out, dio_oen, busy
  );
endinterface

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device model: oversamples the link and serves Quad Read (0xEB)
// and Quad Write (0x38) against an internal byte array.
//
// state  | meaning
// IDLE   | deselected, waiting for ce_n high-then-low
// CMD    | shifting 8 command bits on dio[0]
// ADDR   | shifting 6 address nibbles
// WAIT   | counting read dummy cycles
// RDATA  | driving read nibbles on sck falling edges
// WDATA  | capturing write nibbles on sck rising edges
// IGNORE | unknown command, bus left undriven until deselect
module psram_qspi_responder #(
  parameter int ADDR_BITS = 12,
  parameter int READ_WAIT = 6
) (
  input logic                   clock,
  input logic                   reset,
  psram_qspi_responder_if.slave qspi
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_pipe_q, sck_pipe_d;
  logic [1:0]  ce_pipe_q, ce_pipe_d;
  logic [3:0]  dio_s1_q, dio_s1_d;
  logic [3:0]  dio_s2_q, dio_s2_d;
  logic        armed_q, armed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        is_wr_q, is_wr_d;
  logic [23:0] addr_q, addr_d;
  logic        nib_hi_q, nib_hi_d;
  logic [3:0]  wr_hi_q, wr_hi_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic [3:0]  dio_out_q, dio_out_d;
  logic [3:0]  dio_oen_q, dio_oen_d;
  logic        busy_q, busy_d;

  logic [7:0]           mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;

  logic        sck_rise, sck_fall, ce_hi;
  logic [23:0] addr_inc;
  logic [7:0]  cmd_next;

  // [1] is the synchronised copy, [2] the delayed copy used for edge detect
  assign sck_rise = sck_pipe_q[1] & ~sck_pipe_q[2];
  assign sck_fall = ~sck_pipe_q[1] & sck_pipe_q[2];
  assign ce_hi    = ce_pipe_q[1];
  assign addr_inc = addr_q + 24'd1;

  always_comb begin
    sck_pipe_d = {sck_pipe_q[1:0], qspi.qspi_sck};
    ce_pipe_d  = {ce_pipe_q[0], qspi.qspi_ce_n};
    dio_s1_d   = qspi.dio_in;
    dio_s2_d   = dio_s1_q;
    state_d    = state_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    cmd_next   = {cmd_q[6:0], dio_s2_q[0]};
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    nib_hi_d   = nib_hi_q;
    wr_hi_d    = wr_hi_q;
    rd_byte_d  = rd_byte_q;
    dio_out_d  = dio_out_q;
    dio_oen_d  = dio_oen_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q[ADDR_BITS-1:0];
    mem_wdata  = {wr_hi_q, dio_s2_q};

    if (ce_hi) begin
      // deselect beats any coincident sck edge and drops partial nibbles
      state_d   = ST_IDLE;
      armed_d   = 1'b1;
      nib_hi_d  = 1'b0;
      dio_out_d = 4'h0;
      dio_oen_d = 4'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_CMD;
            armed_d = 1'b0;
            cmd_d   = 8'h00;
            cnt_d   = 8'd7;
            if (sck_rise) begin
              cmd_d = {7'd0, dio_s2_q[0]};
              cnt_d = 8'd6;
            end
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
              cnt_d = 8'd5;
              if (cmd_next == 8'hEB) begin
                state_d = ST_ADDR;
                is_wr_d = 1'b0;
              end else if (cmd_next == 8'h38) begin
                state_d = ST_ADDR;
                is_wr_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[19:0], dio_s2_q};
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
              nib_hi_d = 1'b0;
              if (is_wr_q) begin
                state_d = ST_WDATA;
              end else if (READ_WAIT == 0) begin
                state_d   = ST_RDATA;
                rd_byte_d = mem_q[addr_d[ADDR_BITS-1:0]];
              end else begin
                state_d = ST_WAIT;
                cnt_d   = 8'(READ_WAIT - 1);
              end
            end
          end
        end
        ST_WAIT: begin
          if (sck_rise) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
              state_d   = ST_RDATA;
              rd_byte_d = mem_q[addr_q[ADDR_BITS-1:0]];
            end
          end
        end
        ST_RDATA: begin
          if (sck_fall) begin
            dio_oen_d = 4'hF;
            if (!nib_hi_q) begin
              dio_out_d = rd_byte_q[7:4];
              nib_hi_d  = 1'b1;
            end else begin
              dio_out_d = rd_byte_q[3:0];
              nib_hi_d  = 1'b0;
              addr_d    = addr_inc;
              rd_byte_d = mem_q[addr_inc[ADDR_BITS-1:0]];
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            if (!nib_hi_q) begin
              wr_hi_d  = dio_s2_q;
              nib_hi_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              nib_hi_d = 1'b0;
              addr_d   = addr_inc;
            end
          end
        end
        ST_IGNORE: begin
          dio_oen_d = 4'h0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sck_pipe_q <= '0;
      ce_pipe_q  <= '0;
      dio_s1_q   <= '0;
      dio_s2_q   <= '0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      nib_hi_q   <= 1'b0;
      wr_hi_q    <= '0;
      rd_byte_q  <= '0;
      dio_out_q  <= '0;
      dio_oen_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_pipe_q <= sck_pipe_d;
      ce_pipe_q  <= ce_pipe_d;
      dio_s1_q   <= dio_s1_d;
      dio_s2_q   <= dio_s2_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      nib_hi_q   <= nib_hi_d;
      wr_hi_q    <= wr_hi_d;
      rd_byte_q  <= rd_byte_d;
      dio_out_q  <= dio_out_d;
      dio_oen_q  <= dio_oen_d;
      busy_q     <= busy_d;
    end
  end

  // array contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign qspi.dio_out = dio_out_q;
  assign qspi.dio_oen = dio_oen_q;
  assign qspi.busy    = busy_q;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: drives the QSPI master side and checks
// against a byte-array reference model.
module tb_psram_qspi_responder;

  localparam int H     = 6;
  localparam int DEPTH = 4096;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  psram_qspi_responder_if bus ();

  psram_qspi_responder #(.ADDR_BITS(12), .READ_WAIT(6)) dut (
    .clock (clock),
    .reset (reset),
    .qspi  (bus.slave)
  );

  int         vectors;
  int         miscompares;
  int         early_oen_bad;
  logic [7:0] ref_mem   [DEPTH];
  bit         ref_valid [DEPTH];
  logic [7:0] wr_buf    [64];
  logic [3:0] cap_nib   [128];
  logic [3:0] cap_oen   [128];

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] s_out, output logic [3:0] s_oen);
    bus.qspi_sck = 1'b0;
    bus.dio_in   = nib;
    clk(H);
    s_out = bus.dio_out;
    s_oen = bus.dio_oen;
    bus.qspi_sck = 1'b1;
    clk(H);
  endtask

  task automatic start_tx(input logic [7:0] cmd, input logic [23:0] addr);
    logic [3:0] o, e;
    bus.qspi_ce_n = 1'b0;
    clk(2);
    for (int i = 7; i >= 0; i--) begin
      sck_cycle({3'($urandom), cmd[i]}, o, e);
      if (e != 4'h0) early_oen_bad++;
    end
    for (int k = 5; k >= 0; k--) begin
      sck_cycle(addr[4*k +: 4], o, e);
      if (e != 4'h0) early_oen_bad++;
    end
  endtask

  task automatic end_tx();
    bus.qspi_ce_n = 1'b1;
    clk(2);
    bus.qspi_sck = 1'b0;
    clk(4);
  endtask

  task automatic qspi_write(input logic [23:0] addr, input int n);
    logic [3:0] o, e;
    start_tx(8'h38, addr);
    for (int b = 0; b < n; b++) begin
      sck_cycle(wr_buf[b][7:4], o, e);
      if (e != 4'h0) early_oen_bad++;
      sck_cycle(wr_buf[b][3:0], o, e);
      if (e != 4'h0) early_oen_bad++;
    end
    end_tx();
  endtask

  task automatic qspi_read(input logic [23:0] addr, input int n);
    logic [3:0] o, e;
    start_tx(8'hEB, addr);
    for (int d = 0; d < 6; d++) begin
      sck_cycle(4'($urandom), o, e);
      if (e != 4'h0) early_oen_bad++;
    end
    for (int k = 0; k < 2 * n; k++) begin
      sck_cycle(4'($urandom), o, e);
      cap_nib[k] = o;
      cap_oen[k] = e;
    end
    end_tx();
  endtask

  task automatic model_write(input logic [23:0] addr, input int n);
    for (int b = 0; b < n; b++) begin
      ref_mem[(int'(addr[11:0]) + b) % DEPTH]   = wr_buf[b];
      ref_valid[(int'(addr[11:0]) + b) % DEPTH] = 1'b1;
    end
  endtask

  function automatic logic [3:0] exp_nib(input logic [23:0] addr, input int k);
    logic [7:0] b;
    b = ref_mem[(int'(addr[11:0]) + k / 2) % DEPTH];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic bit exp_valid(input logic [23:0] addr, input int k);
    return ref_valid[(int'(addr[11:0]) + k / 2) % DEPTH];
  endfunction

  task automatic test_reset();
    logic [3:0] o, e;
    reset = 1'b1;
    bus.qspi_ce_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(4'($urandom), o, e);
      vectors++;
      if (e !== 4'h0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: oen=%h busy=%b required oen=0 busy=0", e, bus.busy);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(4'($urandom), o, e);
      vectors++;
      if (e !== 4'h0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stay_idle: oen=%h busy=%b required oen=0 busy=0", e, bus.busy);
      end
    end
    bus.qspi_sck = 1'b0;
    bus.qspi_ce_n = 1'b1;
    clk(4);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ce_high: busy=%b required 0", bus.busy);
    end
    bus.qspi_ce_n = 1'b0;
    clk(4);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_reselect: busy=%b required 1", bus.busy);
    end
    end_tx();
    vectors++;
    if (bus.busy !== 1'b0 || bus.dio_oen !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_deselect: busy=%b oen=%h required 0/0", bus.busy, bus.dio_oen);
    end
  endtask

  task automatic test_write_read();
    wr_buf[0] = 8'h12; wr_buf[1] = 8'h34; wr_buf[2] = 8'h56; wr_buf[3] = 8'h78;
    early_oen_bad = 0;
    qspi_write(24'h000010, 4);
    model_write(24'h000010, 4);
    qspi_read(24'h000010, 4);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (cap_nib[k] !== exp_nib(24'h000010, k) || cap_oen[k] !== 4'hF) begin
        miscompares++;
        $display("FAIL write_read nib%0d: got %h oen %h required %h oen F",
                 k, cap_nib[k], cap_oen[k], exp_nib(24'h000010, k));
      end
    end
    vectors++;
    if (early_oen_bad != 0 || bus.dio_oen !== 4'h0) begin
      miscompares++;
      $display("FAIL write_read_oen: early drives=%0d oen_after=%h required 0/0",
               early_oen_bad, bus.dio_oen);
    end
  endtask

  task automatic test_wrap();
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
    qspi_write(24'h000FFF, 2);
    model_write(24'h000FFF, 2);
    qspi_read(24'h001FFF, 2);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (cap_nib[k] !== exp_nib(24'h001FFF, k) || cap_oen[k] !== 4'hF) begin
        miscompares++;
        $display("FAIL wrap nib%0d: got %h oen %h required %h oen F",
                 k, cap_nib[k], cap_oen[k], exp_nib(24'h001FFF, k));
      end
    end
    qspi_read(24'h000000, 1);
    vectors++;
    if ({cap_nib[0], cap_nib[1]} !== ref_mem[0]) begin
      miscompares++;
      $display("FAIL wrap_low_byte: got %h required %h", {cap_nib[0], cap_nib[1]}, ref_mem[0]);
    end
  endtask

  task automatic test_abort();
    logic [3:0] o, e;
    wr_buf[0] = 8'hAA; wr_buf[1] = 8'hBB;
    qspi_write(24'h000020, 2);
    model_write(24'h000020, 2);
    start_tx(8'h38, 24'h000020);
    sck_cycle(4'h5, o, e);
    sck_cycle(4'hC, o, e);
    sck_cycle(4'h7, o, e);
    // fourth nibble's rising edge coincides with deselect: must not write
    bus.qspi_sck = 1'b0;
    bus.dio_in   = 4'hE;
    clk(H);
    bus.qspi_sck  = 1'b1;
    bus.qspi_ce_n = 1'b1;
    clk(4);
    vectors++;
    if (bus.dio_oen !== 4'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_release: oen=%h busy=%b required 0/0", bus.dio_oen, bus.busy);
    end
    bus.qspi_sck = 1'b0;
    clk(4);
    wr_buf[0] = 8'h5C;
    model_write(24'h000020, 1);
    qspi_read(24'h000020, 2);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (cap_nib[k] !== exp_nib(24'h000020, k)) begin
        miscompares++;
        $display("FAIL abort nib%0d: got %h required %h", k, cap_nib[k], exp_nib(24'h000020, k));
      end
    end
  endtask

  task automatic test_unknown_cmd();
    logic [3:0] o, e;
    int bad;
    bad = 0;
    bus.qspi_ce_n = 1'b0;
    clk(2);
    for (int i = 7; i >= 0; i--) begin
      sck_cycle({3'($urandom), 1'(8'h05 >> i)}, o, e);
      if (e !== 4'h0) bad++;
    end
    for (int i = 0; i < 20; i++) begin
      sck_cycle(4'($urandom), o, e);
      if (e !== 4'h0) bad++;
    end
    vectors++;
    if (bad != 0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL unknown_cmd: drive samples=%0d busy=%b required 0 and 1", bad, bus.busy);
    end
    end_tx();
    qspi_read(24'h000010, 4);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (cap_nib[k] !== exp_nib(24'h000010, k) || cap_oen[k] !== 4'hF) begin
        miscompares++;
        $display("FAIL unknown_then_read nib%0d: got %h oen %h required %h oen F",
                 k, cap_nib[k], cap_oen[k], exp_nib(24'h000010, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] o, e;
    start_tx(8'hEB, 24'h000010);
    for (int d = 0; d < 8; d++) sck_cycle(4'h0, o, e);
    vectors++;
    if (e !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_mid_pre: oen=%h required F", e);
    end
    @(posedge clock);
    reset = 1'b1;
    clk(1);
    reset = 1'b0;
    vectors++;
    if (bus.dio_oen !== 4'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: oen=%h busy=%b required 0/0", bus.dio_oen, bus.busy);
    end
    for (int i = 0; i < 4; i++) sck_cycle(4'($urandom), o, e);
    vectors++;
    if (bus.busy !== 1'b0 || e !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid_stay: busy=%b oen=%h required 0/0", bus.busy, e);
    end
    end_tx();
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    int n;
    for (int t = 0; t < 24; t++) begin
      a = {12'($urandom), 12'(12'hFF0 + $urandom_range(0, 31))};
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < n; b++) wr_buf[b] = 8'($urandom);
        qspi_write(a, n);
        model_write(a, n);
      end else begin
        qspi_read(a, n);
        for (int k = 0; k < 2 * n; k++) begin
          if (exp_valid(a, k)) begin
            vectors++;
            if (cap_nib[k] !== exp_nib(a, k) || cap_oen[k] !== 4'hF) begin
              miscompares++;
              $display("FAIL random_read a=%h nib%0d: got %h oen %h required %h oen F",
                       a, k, cap_nib[k], cap_oen[k], exp_nib(a, k));
            end
          end
        end
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    early_oen_bad = 0;
    reset         = 1'b1;
    bus.qspi_sck  = 1'b0;
    bus.qspi_ce_n = 1'b0;
    bus.dio_in    = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 8'h00;
      ref_valid[i] = 1'b0;
    end
    clk(4);
    test_reset();
    test_write_read();
    test_wrap();
    test_abort();
    test_unknown_cmd();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
